// File: rtl/fa32_selftest_pkg.sv
// Shared types and constants for the 32-bit full-adder self-test sequencer:
// FSM states, the directed vector table and LFSR parameters.
package fa32_selftest_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int          NUM_DIRECTED = 10;
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

  // Each entry is {a, b, cin}; element [0] is vector 0.
  localparam logic [NUM_DIRECTED-1:0][64:0] DIRECTED_VECTORS = {
    {32'h8000_0000, 32'h8000_0000, 1'b1},
    {32'h0000_0000, 32'h8000_0000, 1'b1},
    {32'h0000_0000, 32'h8000_0000, 1'b0},
    {32'h8000_0000, 32'h0000_0000, 1'b0},
    {32'h0000_0001, 32'h0000_0001, 1'b1},
    {32'h0000_0000, 32'h0000_0001, 1'b0},
    {32'h0000_0001, 32'h0000_0000, 1'b0},
    {32'h0000_0000, 32'h0000_0000, 1'b1},
    {32'h0000_0000, 32'h0000_0000, 1'b0},
    {32'hAAAA_AAAA, 32'h5555_5555, 1'b0}
  };

  function automatic logic [32:0] add_ref(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic        c);
    return {1'b0, x} + {1'b0, y} + {32'b0, c};
  endfunction

endpackage

// File: rtl/fa32_lfsr32.sv
// One combinational advance of the 32-bit right-shifting Galois LFSR.
module fa32_lfsr32
  import fa32_selftest_pkg::*;
(
  input  logic [31:0] lfsr_now,
  output logic [31:0] lfsr_next
);

  assign lfsr_next = (lfsr_now >> 1) ^ (lfsr_now[0] ? LFSR_TAPS : 32'h0);

endmodule

// File: rtl/fa32_selftest.sv
// Synthesizable stimulus generator and checker for a 32-bit full adder:
// drives directed then LFSR vectors, waits a settle interval, counts matches.
module fa32_selftest
  import fa32_selftest_pkg::*;
#(
  parameter int          NUM_RANDOM    = 50,
  parameter int          SETTLE_CYCLES = 10,
  parameter logic [31:0] LFSR_SEED     = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        global_resetn,
  input  logic        start,
  input  logic [31:0] sum,
  input  logic        cout,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        cin,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pass_count,
  output logic [7:0]  fail_count,
  output logic [7:0]  first_fail_idx
);

  localparam logic [7:0]  LAST_IDX    = 8'(NUM_DIRECTED - 1 + NUM_RANDOM);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [31:0] SEED_EFF    = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

  state_t      state, next_state;
  logic        start_q;
  logic [7:0]  vec_idx;
  logic [15:0] settle_cnt;
  logic [31:0] lfsr, step1, step2, step3;
  logic [32:0] expected;
  logic [64:0] load_vec;
  logic        is_random;
  logic        match;

  fa32_lfsr32 u_step1 (.lfsr_now(lfsr),  .lfsr_next(step1));
  fa32_lfsr32 u_step2 (.lfsr_now(step1), .lfsr_next(step2));
  fa32_lfsr32 u_step3 (.lfsr_now(step2), .lfsr_next(step3));

  assign is_random = (vec_idx >= 8'(NUM_DIRECTED));
  assign match     = ({cout, sum} == expected);

  always_comb begin
    load_vec = {step1, step2, step3[0]};
    if (!is_random) load_vec = DIRECTED_VECTORS[vec_idx[3:0]];
  end

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) state <= S_IDLE;
    else                state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE, S_DONE: if (start_q) next_state = S_LOAD;
      S_LOAD:         next_state = S_SETTLE;
      S_SETTLE:       if (settle_cnt == SETTLE_LAST) next_state = S_CHECK;
      S_CHECK:        next_state = (vec_idx == LAST_IDX) ? S_DONE : S_LOAD;
      default:        next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_LOAD) || (state == S_SETTLE) || (state == S_CHECK);
    done = (state == S_DONE);
  end

  // start is registered first, so busy follows one edge after start is seen.
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      start_q        <= 1'b0;
      a              <= '0;
      b              <= '0;
      cin            <= 1'b0;
      expected       <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= 8'hFF;
      lfsr           <= SEED_EFF;
      vec_idx        <= '0;
      settle_cnt     <= '0;
    end else begin
      start_q <= start & ~busy;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start_q) begin
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= 8'hFF;
            vec_idx        <= '0;
            lfsr           <= SEED_EFF;
          end
        end
        S_LOAD: begin
          a          <= load_vec[64:33];
          b          <= load_vec[32:1];
          cin        <= load_vec[0];
          expected   <= add_ref(load_vec[64:33], load_vec[32:1], load_vec[0]);
          settle_cnt <= '0;
          if (is_random) lfsr <= step3;
        end
        S_SETTLE: settle_cnt <= settle_cnt + 16'd1;
        S_CHECK: begin
          if (match) begin
            if (pass_count != 8'hFF) pass_count <= pass_count + 8'd1;
          end else begin
            if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
            if (first_fail_idx == 8'hFF) first_fail_idx <= vec_idx;
          end
          if (vec_idx != LAST_IDX) vec_idx <= vec_idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fa32_selftest.sv
// Directed bench for fa32_selftest: a behavioural adder with selectable faults
// and result latency sits between the operand outputs and the result inputs.
module tb_fa32_selftest;

  localparam int F_IDEAL = 0;
  localparam int F_SUM31 = 1;
  localparam int F_COUT  = 2;
  localparam int F_LAT10 = 3;
  localparam int F_LAT11 = 4;

  logic        clk;
  logic        global_resetn;
  logic        start;
  logic [31:0] sum, a, b;
  logic        cout, cin, busy, done;
  logic [7:0]  pass_count, fail_count, first_fail_idx;

  int fault_mode;
  int errors;
  int checks;
  int done_cycles;

  logic [32:0] ideal, res;
  logic [32:0] pipe [12];

  fa32_selftest dut (
    .clk           (clk),
    .global_resetn (global_resetn),
    .start         (start),
    .sum           (sum),
    .cout          (cout),
    .a             (a),
    .b             (b),
    .cin           (cin),
    .busy          (busy),
    .done          (done),
    .pass_count    (pass_count),
    .fail_count    (fail_count),
    .first_fail_idx(first_fail_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ideal = {1'b0, a} + {1'b0, b} + {32'b0, cin};

  // pipe[L-1] models an adder whose result appears L cycles after its operands.
  always @(posedge clk) begin
    pipe[0] <= ideal;
    for (int i = 1; i < 12; i++) pipe[i] <= pipe[i-1];
  end

  always_comb begin
    res = ideal;
    if (fault_mode == F_LAT10) res = pipe[9];
    else if (fault_mode == F_LAT11) res = pipe[10];
    if (fault_mode == F_SUM31) res[31] = 1'b0;
    if (fault_mode == F_COUT)  res[32] = 1'b0;
  end

  assign {cout, sum} = res;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_a"},     a, 0);
    checkOutput({tag, "_b"},     b, 0);
    checkOutput({tag, "_cin"},   cin, 0);
    checkOutput({tag, "_busy"},  busy, 0);
    checkOutput({tag, "_done"},  done, 0);
    checkOutput({tag, "_pass"},  pass_count, 0);
    checkOutput({tag, "_fail"},  fail_count, 0);
    checkOutput({tag, "_first"}, first_fail_idx, 8'hFF);
  endtask

  task automatic checkVector(input int v, input logic [31:0] ea,
                             input logic [31:0] eb, input logic ec);
    checkOutput($sformatf("v%0d_a", v),   a,   ea);
    checkOutput($sformatf("v%0d_b", v),   b,   eb);
    checkOutput($sformatf("v%0d_cin", v), cin, ec);
  endtask

  // Pulses start (edge k is the first edge seeing it) and runs to done,
  // optionally re-pulsing start mid-run or dropping reset during vector 12.
  task automatic applyStimulus(input bit pulse_mid, input bit reset_mid);
    done_cycles = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checkOutput("busy_at_k", busy, 0);
    for (int n = 1; n <= 800; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        checkOutput("busy_at_k1", busy, 1);
        checkOutput("done_cleared", done, 0);
      end
      if (n == 6)   checkVector(0,  32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
      if (n == 114) checkVector(9,  32'h8000_0000, 32'h8000_0000, 1'b1);
      if (n == 126) checkVector(10, 32'h8020_0003, 32'hC030_0002, 1'b1);
      if (n == 138) checkVector(11, 32'hB02C_0003, 32'hD836_0002, 1'b1);
      if (pulse_mid && n == 39) start = 1'b1;
      if (pulse_mid && n == 40) start = 1'b0;
      if (reset_mid && n == 150) global_resetn = 1'b0;
      if (reset_mid && n == 151) begin
        global_resetn = 1'b1;
        return;
      end
      if (done) begin
        done_cycles = n;
        break;
      end
    end
    checkOutput("done_latency", done_cycles, 721);
    checkOutput("busy_after_done", busy, 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    fault_mode = F_IDEAL;
    start = 1'b0;
    global_resetn = 1'b0;
    waitCycles(15);
    checkResetValues("reset");
    global_resetn = 1'b1;
    waitCycles(2);

    $display("[TB] ideal adder run");
    applyStimulus(1'b0, 1'b0);
    checkOutput("ideal_pass", pass_count, 60);
    checkOutput("ideal_fail", fail_count, 0);
    checkOutput("ideal_first", first_fail_idx, 8'hFF);
    waitCycles(5);
    checkOutput("done_held", done, 1);

    $display("[TB] sum[31] stuck at 0");
    fault_mode = F_SUM31;
    applyStimulus(1'b0, 1'b0);
    checkOutput("sum31_first", first_fail_idx, 0);
    checkOutput("sum31_fail_nonzero", fail_count != 8'd0, 1);
    checkOutput("sum31_total", 64'(pass_count) + 64'(fail_count), 60);

    $display("[TB] cout forced to 0");
    fault_mode = F_COUT;
    applyStimulus(1'b0, 1'b0);
    checkOutput("cout_first", first_fail_idx, 9);
    checkOutput("cout_total", 64'(pass_count) + 64'(fail_count), 60);

    $display("[TB] result latency beyond settle interval");
    fault_mode = F_LAT11;
    applyStimulus(1'b0, 1'b0);
    checkOutput("lat11_fail_nonzero", fail_count != 8'd0, 1);

    $display("[TB] result latency equal to settle interval");
    fault_mode = F_LAT10;
    applyStimulus(1'b0, 1'b0);
    checkOutput("lat10_pass", pass_count, 60);
    checkOutput("lat10_fail", fail_count, 0);

    $display("[TB] start re-pulsed while busy");
    fault_mode = F_IDEAL;
    applyStimulus(1'b1, 1'b0);
    checkOutput("repulse_pass", pass_count, 60);
    checkOutput("repulse_fail", fail_count, 0);
    checkOutput("repulse_first", first_fail_idx, 8'hFF);

    $display("[TB] reset during vector 12");
    applyStimulus(1'b0, 1'b1);
    checkResetValues("midreset");
    waitCycles(5);
    checkOutput("midreset_done_low", done, 0);
    checkOutput("midreset_busy_low", busy, 0);

    $display("[TB] run after mid-run reset");
    applyStimulus(1'b0, 1'b0);
    checkOutput("rerun_pass", pass_count, 60);
    checkOutput("rerun_fail", fail_count, 0);
    checkOutput("rerun_first", first_fail_idx, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fa32_selftest.md
# fa32_selftest

On-fabric stimulus generator and result checker for the 32-bit full adder under test. It sits directly upstream and downstream of the adder. It drives `a`, `b` and `cin`, waits a fixed settle interval, then compares the adder's `{cout,sum}` against an internally computed 33-bit reference. Pass/fail counts are reported to the bitstream-level bench, replacing per-vector `$display` checking with a synthesizable sequence.

## Interface
Parameters:
- `NUM_RANDOM`, 50: number of pseudo-random vectors run after the directed set. 10 + `NUM_RANDOM` must be ≤ 255.
- `SETTLE_CYCLES`, 10: cycles the operands are held before sampling the result. Must be ≥ 1.
- `LFSR_SEED`, 32'h0000_0001: LFSR load value. A value of 0 is replaced by 1.

Ports (one clock, `clk`; reset `global_resetn` is asynchronous, active-low):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `global_resetn`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle run request.
- `sum`  in  32  adder result.
- `cout`  in  1  adder carry-out.
- `a`  out  32  operand A, registered.
- `b`  out  32  operand B, registered.
- `cin`  out  1  carry-in, registered.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high once a run completes; held until the next start or reset.
- `pass_count`  out  8  vectors that matched.
- `fail_count`  out  8  vectors that mismatched.
- `first_fail_idx`  out  8  index of the first mismatching vector; 8'hFF if none.

## Operation
- **Reset values:** `a`, `b`, `cin`, `busy`, `done`, `pass_count`, `fail_count` = 0; `first_fail_idx` = 8'hFF; LFSR = seed; state IDLE; vector index = 0.
- **States:** IDLE, LOAD, SETTLE, CHECK, DONE.
- **IDLE/DONE + `start`:** clear the counters, set `first_fail_idx` = FF, set index = 0, reseed the LFSR, clear `done`, set `busy`, go to LOAD.
- **`start` while `busy`:** ignored.
- **Directed vectors, index 0–9, as (a, b, cin):**
  - 0: (AAAAAAAA, 55555555, 0)
  - 1: (0, 0, 0)
  - 2: (0, 0, 1)
  - 3: (1, 0, 0)
  - 4: (0, 1, 0)
  - 5: (1, 1, 1)
  - 6: (80000000, 0, 0)
  - 7: (0, 80000000, 0)
  - 8: (0, 80000000, 1)
  - 9: (80000000, 80000000, 1)
- **Random vectors, index ≥ 10:**
  - The LFSR is a 32-bit Galois register with taps 32'h8020_0003, shifting right.
  - Each vector takes three advances: `a` = state after step 1, `b` = state after step 2, `cin` = bit 0 after step 3.
  - All three steps are computed combinationally within LOAD.
- **LOAD (1 cycle):** register `a`, `b`, `cin` and the expected value `{1'b0,a}+{1'b0,b}+cin` (33-bit). Go to SETTLE.
- **SETTLE:** count `SETTLE_CYCLES` cycles, then go to CHECK.
- **CHECK (1 cycle):** compare `{cout,sum}` with the expected value.
  - Match: increment `pass_count`.
  - Mismatch: increment `fail_count`; if `first_fail_idx` = FF, load the current index.
  - Both counters saturate at 255.
  - If index = 9 + `NUM_RANDOM`, go to DONE. Otherwise increment index and go to LOAD.
- **DONE:** `busy` = 0, `done` = 1. Operands hold their last values.

## Timing
- Per-vector cost is `SETTLE_CYCLES` + 2 cycles.
- `start` is sampled at edge k. `done` rises at edge k + 1 + (10+`NUM_RANDOM`)·(`SETTLE_CYCLES`+2). With defaults, that is k + 721.
- `busy` rises at edge k+1.
- Operands change only on the edge leaving LOAD. They are stable for `SETTLE_CYCLES`+1 cycles before sampling.
- `sum`/`cout` are sampled only in CHECK. They are not synchronized; the DUT path is treated as combinational/same-clock.
- Reset asserted mid-run forces all reset values immediately. `done` is not raised and no partial counts are retained.

## Structure
- **Package `fa32_selftest_pkg`:** state enum, the directed-vector constant array (10 × 65 bits), LFSR tap constant, default seed.
- **Sub-module `fa32_lfsr32`:** combinational one-step Galois advance, instantiated three times in a chain. The state register lives in the parent.

## Test plan
- **Ideal adder model, defaults, pulse `start`:** `done` at +721 cycles; `pass_count` = 60, `fail_count` = 0, `first_fail_idx` = FF.
- **`sum[31]` stuck at 0:** vector 0 fails (expects FFFFFFFF); `first_fail_idx` = 0; `fail_count` ≥ 1; `pass_count` + `fail_count` = 60.
- **`cout` forced to 0:** the only directed failure is index 9 (expects {1, 00000001}), so `first_fail_idx` = 9.
- **DUT with `SETTLE_CYCLES` + 1 cycles of result latency:** mismatches are reported (`fail_count` > 0). With `SETTLE_CYCLES` cycles of latency, all 60 vectors pass.
- **`start` re-pulsed while busy:**
  - Pulse during vector 3: ignored, and the final counts are identical to the first scenario.
  - Pulse after `done`: the run repeats with identical `a`/`b` sequences.
- **`global_resetn` low for 1 cycle during SETTLE of vector 12:** all outputs return to reset values and `done` stays 0. A subsequent `start` gives the results of the first scenario.
